airi5c_fpu_arbiter: RTL and testbench

Shares one `airi5c_FPU` instance between two requesters: port 0 is the core pipeline, port 1 is an auxiliary master such as a vector/DSP unit or debug. It arbitrates the requests, issues the winning operation to the FPU with a one-cycle `load` pulse, and tracks the operation to completion. It then returns the result and flags to the owning requester only. It also forwards per-requester kills and aborts hung operations with a watchdog.

---
 rtl/airi5c_fpu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_airi5c_fpu_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : airi5c_fpu_arbiter
// Brief    : Shares one airi5c_FPU between the core pipeline (port 0) and an
//            auxiliary master (port 1). Arbitrates, issues with a one-cycle
//            load pulse, tracks the operation to completion, routes the result
//            back to the owner, forwards owner kills and aborts hung
//            operations with a watchdog.
// Config   : AIRI5C_FPU_ARB_RR_EN -- round-robin on ties (default: port 0
//            has fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module airi5c_fpu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    // requester 0 (core pipeline)
    input  logic        req0,
    input  logic [4:0]  op0,
    input  logic [2:0]  rm0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] c0,
    input  logic        kill0,
    output logic        gnt0,
    output logic        done0,
    output logic [31:0] res0,
    output logic [4:0]  flags0,
    output logic        tout0,
    // requester 1 (auxiliary master)
    input  logic        req1,
    input  logic [4:0]  op1,
    input  logic [2:0]  rm1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [31:0] c1,
    input  logic        kill1,
    output logic        gnt1,
    output logic        done1,
    output logic [31:0] res1,
    output logic [4:0]  flags1,
    output logic        tout1,
    // FPU command
    output logic        fpu_load,
    output logic        fpu_kill,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    // FPU response
    input  logic [31:0] fpu_result,
    input  logic        fpu_iv,
    input  logic        fpu_dz,
    input  logic        fpu_of,
    input  logic        fpu_uf,
    input  logic        fpu_ie,
    input  logic        fpu_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

    localparam logic [31:0] c_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [4:0]  c_TOUT_FLAGS = 5'b10000;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_owner;
    logic        w_pick;
    logic        w_own_kill;
    logic        w_wdt_expire;
    logic        w_grant;
    logic        w_kill;
    logic        w_complete;
    logic        w_timeout;
    logic [4:0]  w_flags_in;

    logic [4:0]  r_fpu_op;
    logic [2:0]  r_fpu_rm;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;
    logic [31:0] r_fpu_c;
    logic        r_fpu_kill;
    logic [31:0] r_res0;
    logic [31:0] r_res1;
    logic [4:0]  r_flags0;
    logic [4:0]  r_flags1;
    logic        r_done0;
    logic        r_done1;
    logic        r_tout0;
    logic        r_tout1;

    assign w_own_kill = r_owner ? kill1 : kill0;
    assign w_flags_in = {fpu_iv, fpu_dz, fpu_of, fpu_uf, fpu_ie};

`ifdef AIRI5C_FPU_ARB_RR_EN
    logic r_last;

    // On a tie the port that was not granted last wins; a lone request always wins.
    assign w_pick = (req0 && req1) ? ~r_last : req1;

    // Remember the most recently granted port.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_pick;
        end
    end
`else
    // Port 0 always wins when it is requesting.
    assign w_pick = ~req0;
`endif

    generate
        if (TIMEOUT > 0) begin : g_wdt
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_wdt;

            // Count cycles spent waiting on the FPU; restart at every issue.
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    r_wdt <= '0;
                end else if (r_state == S_ISSUE) begin
                    r_wdt <= '0;
                end else if ((r_state == S_GUARD) || (r_state == S_BUSY)) begin
                    r_wdt <= r_wdt + CW'(1);
                end
            end

            // Expire at the end of the TIMEOUT-th waiting cycle.
            assign w_wdt_expire = ((r_state == S_GUARD) || (r_state == S_BUSY)) &&
                                  (r_wdt == CW'(TIMEOUT - 1));
        end else begin : g_no_wdt
            assign w_wdt_expire = 1'b0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle events; kill beats ready, ready beats the watchdog.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_kill       = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_own_kill) begin
                    w_kill       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_GUARD;
                end
            end
            S_GUARD: begin
                // The FPU has not consumed the load yet, so fpu_ready is stale here.
                if (w_own_kill) begin
                    w_kill       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_wdt_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_own_kill) begin
                    w_kill       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (fpu_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_wdt_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command capture, result routing, pulses and sticky timeout flags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_owner    <= 1'b0;
            r_fpu_op   <= '0;
            r_fpu_rm   <= '0;
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
            r_fpu_c    <= '0;
            r_fpu_kill <= 1'b0;
            r_res0     <= '0;
            r_res1     <= '0;
            r_flags0   <= '0;
            r_flags1   <= '0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_tout0    <= 1'b0;
            r_tout1    <= 1'b0;
        end else begin
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_fpu_kill <= 1'b0;

            if (w_grant) begin
                r_owner  <= w_pick;
                r_fpu_op <= w_pick ? op1 : op0;
                r_fpu_rm <= w_pick ? rm1 : rm0;
                r_fpu_a  <= w_pick ? a1  : a0;
                r_fpu_b  <= w_pick ? b1  : b0;
                r_fpu_c  <= w_pick ? c1  : c0;
                if (w_pick) begin
                    r_tout1 <= 1'b0;
                end else begin
                    r_tout0 <= 1'b0;
                end
            end

            if (w_kill) begin
                r_fpu_kill <= 1'b1;
            end

            if (w_complete) begin
                if (r_owner) begin
                    r_res1   <= fpu_result;
                    r_flags1 <= w_flags_in;
                    r_done1  <= 1'b1;
                end else begin
                    r_res0   <= fpu_result;
                    r_flags0 <= w_flags_in;
                    r_done0  <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_fpu_kill <= 1'b1;
                if (r_owner) begin
                    r_res1   <= c_CANON_NAN;
                    r_flags1 <= c_TOUT_FLAGS;
                    r_done1  <= 1'b1;
                    r_tout1  <= 1'b1;
                end else begin
                    r_res0   <= c_CANON_NAN;
                    r_flags0 <= c_TOUT_FLAGS;
                    r_done0  <= 1'b1;
                    r_tout0  <= 1'b1;
                end
            end
        end
    end

    assign fpu_load = (r_state == S_ISSUE);
    assign gnt0     = (r_state == S_ISSUE) && !r_owner;
    assign gnt1     = (r_state == S_ISSUE) &&  r_owner;
    assign fpu_kill = r_fpu_kill;
    assign fpu_op   = r_fpu_op;
    assign fpu_rm   = r_fpu_rm;
    assign fpu_a    = r_fpu_a;
    assign fpu_b    = r_fpu_b;
    assign fpu_c    = r_fpu_c;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign flags0   = r_flags0;
    assign flags1   = r_flags1;
    assign tout0    = r_tout0;
    assign tout1    = r_tout1;

endmodule
`default_nettype wire

// File: tb/tb_airi5c_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_airi5c_fpu_arbiter
// Brief    : Directed self-checking bench for airi5c_fpu_arbiter; the FPU
//            response is driven directly by the stimulus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_airi5c_fpu_arbiter;

    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_MUL = 5'd2;
    localparam logic [4:0] c_OP_DIV = 5'd3;

    logic        clk;
    logic        n_reset;
    logic        req0, req1, kill0, kill1;
    logic [4:0]  op0, op1;
    logic [2:0]  rm0, rm1;
    logic [31:0] a0, b0, c0, a1, b1, c1;
    logic        gnt0, gnt1, done0, done1, tout0, tout1;
    logic [31:0] res0, res1;
    logic [4:0]  flags0, flags1;
    logic        fpu_load, fpu_kill;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic [31:0] fpu_result;
    logic        fpu_iv, fpu_dz, fpu_of, fpu_uf, fpu_ie, fpu_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int port;

    airi5c_fpu_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .n_reset(n_reset),
        .req0(req0), .op0(op0), .rm0(rm0), .a0(a0), .b0(b0), .c0(c0), .kill0(kill0),
        .gnt0(gnt0), .done0(done0), .res0(res0), .flags0(flags0), .tout0(tout0),
        .req1(req1), .op1(op1), .rm1(rm1), .a1(a1), .b1(b1), .c1(c1), .kill1(kill1),
        .gnt1(gnt1), .done1(done1), .res1(res1), .flags1(flags1), .tout1(tout1),
        .fpu_load(fpu_load), .fpu_kill(fpu_kill), .fpu_op(fpu_op), .fpu_rm(fpu_rm),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
        .fpu_result(fpu_result), .fpu_iv(fpu_iv), .fpu_dz(fpu_dz), .fpu_of(fpu_of),
        .fpu_uf(fpu_uf), .fpu_ie(fpu_ie), .fpu_ready(fpu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, run the op to completion with the given result.
    task automatic do_op(input logic [31:0] result, output int p);
        p = -1;
        for (int i = 0; i < 10 && !(gnt0 || gnt1); i++) tick();
        chk("gnt_wait", {31'd0, gnt0 || gnt1}, 32'd1);
        if (gnt0) p = 0;
        else if (gnt1) p = 1;
        chk("fpu_a_route", fpu_a, (p == 1) ? a1 : a0);
        tick();                         // GUARD
        tick();                         // BUSY
        fpu_result = result;
        fpu_ready  = 1'b1;
        tick();                         // done pulse
        fpu_ready  = 1'b0;
        chk("done_route", {30'd0, done1, done0}, (p == 1) ? 32'd2 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_reset = 1'b0;
        req0 = 0; req1 = 0; kill0 = 0; kill1 = 0;
        op0 = '0; op1 = '0; rm0 = '0; rm1 = '0;
        a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
        fpu_result = '0; fpu_ready = 0;
        fpu_iv = 0; fpu_dz = 0; fpu_of = 0; fpu_uf = 0; fpu_ie = 0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_ctrl", {26'd0, gnt0, gnt1, done0, done1, fpu_load, fpu_kill}, 32'd0);
        chk("rst_res0", res0, 32'd0);
        chk("rst_flags", {22'd0, flags0, flags1}, 32'd0);
        chk("rst_tout", {30'd0, tout0, tout1}, 32'd0);
        chk("rst_cmd", {24'd0, fpu_op, fpu_rm}, 32'd0);
        n_reset = 1'b1;
        tick();

        // ---- single request: 1.0 + 2.0 = 3.0 ----
        req0 = 1; op0 = c_OP_ADD; rm0 = 3'd0; a0 = 32'h3F80_0000; b0 = 32'h4000_0000; c0 = 32'h0;
        tick();
        chk("single_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        chk("single_load", {31'd0, fpu_load}, 32'd1);
        chk("single_fpu_a", fpu_a, 32'h3F80_0000);
        chk("single_fpu_b", fpu_b, 32'h4000_0000);
        chk("single_fpu_op", {27'd0, fpu_op}, {27'd0, c_OP_ADD});
        req0 = 0;
        tick();                                   // GUARD: stale ready is ignored
        chk("guard_load_low", {31'd0, fpu_load}, 32'd0);
        fpu_result = 32'hDEAD_BEEF; fpu_ready = 1;
        tick();                                   // BUSY
        chk("guard_ready_ignored", {30'd0, done0, done1}, 32'd0);
        fpu_result = 32'h4040_0000; fpu_ready = 1;
        tick();
        fpu_ready = 0;
        chk("single_done0", {30'd0, done0, done1}, 32'd2);
        chk("single_res0", res0, 32'h4040_0000);
        chk("single_flags0", {27'd0, flags0}, 32'd0);
        chk("single_p1_res", res1, 32'd0);
        tick();
        chk("single_done_pulse", {31'd0, done0}, 32'd0);
        chk("single_res0_hold", res0, 32'h4040_0000);

        // ---- tie: both requests held for three operations ----
        op0 = c_OP_MUL; a0 = 32'h1111_1111; op1 = c_OP_DIV; a1 = 32'h2222_2222;
        req0 = 1; req1 = 1;
        do_op(32'hAAAA_0001, port);
        chk("tie_grant1", port, 32'd0);
        do_op(32'hAAAA_0002, port);
`ifdef AIRI5C_FPU_ARB_RR_EN
        chk("tie_grant2", port, 32'd1);
`else
        chk("tie_grant2", port, 32'd0);
`endif
        do_op(32'hAAAA_0003, port);
        req0 = 0; req1 = 0;
        chk("tie_grant3", port, 32'd0);
        chk("tie_res0", res0, 32'hAAAA_0003);
`ifdef AIRI5C_FPU_ARB_RR_EN
        chk("tie_res1", res1, 32'hAAAA_0002);
`else
        chk("tie_res1", res1, 32'd0);
`endif
        tick();

        // ---- kill: DIV on port 1, port 0 pending ----
        req1 = 1; op1 = c_OP_DIV; a1 = 32'h4120_0000; b1 = 32'h0;
        tick();
        chk("kill_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
        req1 = 0; req0 = 1;
        tick();                                   // GUARD
        tick();                                   // BUSY
        kill0 = 1;                                // non-owner kill
        tick();
        kill0 = 0;
        chk("kill_nonowner", {31'd0, fpu_kill}, 32'd0);
        tick();
        chk("kill_nonowner_busy", {31'd0, gnt0}, 32'd0);
        kill1 = 1;
        tick();
        kill1 = 0;
        chk("kill_pulse", {31'd0, fpu_kill}, 32'd1);
        chk("kill_no_done", {30'd0, done0, done1}, 32'd0);
        tick();
        chk("kill_pulse_end", {31'd0, fpu_kill}, 32'd0);
        chk("kill_then_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        chk("kill_no_done1", {31'd0, done1}, 32'd0);
        req0 = 0;

        // ---- kill and ready in the same cycle on port 0 ----
        tick();                                   // GUARD
        tick();                                   // BUSY
        kill0 = 1; fpu_ready = 1; fpu_result = 32'h1234_5678; fpu_dz = 1;
        tick();
        kill0 = 0; fpu_ready = 0; fpu_dz = 0;
        chk("coll_kill", {31'd0, fpu_kill}, 32'd1);
        chk("coll_no_done", {31'd0, done0}, 32'd0);
        chk("coll_res0", res0, 32'hAAAA_0003);
        tick();
        chk("coll_no_done_late", {31'd0, done0}, 32'd0);

        // ---- watchdog with FPU never ready ----
        req0 = 1; op0 = c_OP_DIV;
        tick();                                   // issue cycle
        chk("wdt_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 0;
        repeat (7) tick();
        tick();                                   // 8th waiting cycle
        chk("wdt_not_yet", {30'd0, fpu_kill, done0}, 32'd0);
        tick();
        chk("wdt_kill", {31'd0, fpu_kill}, 32'd1);
        chk("wdt_done0", {30'd0, done0, done1}, 32'd2);
        chk("wdt_res0", res0, 32'h7FC0_0000);
        chk("wdt_flags0", {27'd0, flags0}, 32'h10);
        chk("wdt_tout", {30'd0, tout0, tout1}, 32'd2);
        tick();
        chk("wdt_tout_sticky", {30'd0, tout0, fpu_kill}, 32'd2);
        req0 = 1; op0 = c_OP_ADD;
        tick();
        req0 = 0;
        chk("wdt_tout_clear", {30'd0, gnt0, tout0}, 32'd2);
        tick(); tick();
        fpu_result = 32'h4080_0000; fpu_ready = 1;
        tick();
        fpu_ready = 0;
        chk("wdt_recover_res0", res0, 32'h4080_0000);

        // ---- asynchronous reset during BUSY ----
        req1 = 1; op1 = c_OP_MUL;
        tick();
        req1 = 0;
        tick(); tick();                           // BUSY
        n_reset = 0;
        #1;
        chk("arst_ctrl", {26'd0, gnt0, gnt1, done0, done1, fpu_load, fpu_kill}, 32'd0);
        chk("arst_res0", res0, 32'd0);
        chk("arst_cmd", {24'd0, fpu_op, fpu_rm}, 32'd0);
        chk("arst_fpu_a", fpu_a, 32'd0);
        tick();
        n_reset = 1;
        fpu_ready = 1; fpu_result = 32'h5555_5555;
        tick();
        fpu_ready = 0;
        tick();
        chk("arst_no_done", {28'd0, done0, done1, gnt0, gnt1}, 32'd0);
        chk("arst_res1", res1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
